// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, index width and RAM access-size codes.
package ram_port_arbiter_pkg;

  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage

// File: rtl/ram_port_arbiter_arb_pick.sv
// Combinational winner selector: lowest requesting index (fixed) or first index at/after
// rr_ptr with wrap (round-robin).
module arb_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  idx_t         rr_ptr,
  input  logic         rr_mode,
  output idx_t         idx,
  output logic         valid
);

  idx_t hi_idx;
  idx_t lo_idx;
  logic hi_valid;
  logic lo_valid;

  // Two descending scans leave the lowest match; the "hi" scan is bounded below by rr_ptr.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i] && (!rr_mode || i >= int'(rr_ptr))) begin
        hi_idx   = IDX_W'(i);
        hi_valid = 1'b1;
      end
      if (req[i]) begin
        lo_idx   = IDX_W'(i);
        lo_valid = 1'b1;
      end
    end
    idx   = hi_valid ? hi_idx : lo_idx;
    valid = lo_valid;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// N-master arbiter serialising chip-select transactions onto the shared RAM port,
// with lock override and a per-transaction watchdog.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RR_MODE        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cs,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS-1:0]        m_oe,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_size,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        grant,
  input  logic                          lock_en,
  input  logic [2:0]                    lock_id,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_d_in,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic                          ram_oe,
  output logic [1:0]                    ram_data_size,
  input  logic [DATA_W-1:0]             ram_d_out,
  input  logic                          ram_ready,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        RR    = (RR_MODE != 0);

  state_t                   state_q, state_d;
  idx_t                     owner_q, owner_d;
  idx_t                     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0]   req, elig;
  idx_t                     pick_idx;
  logic                     pick_valid;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic [1:0]               sel_size;
  logic                     sel_we, sel_oe;
  logic                     done, tout;

  logic [NUM_MASTERS-1:0]   m_ready_d, grant_d;
  logic [DATA_W-1:0]        m_rdata_d, ram_d_in_d;
  logic [ADDR_W-1:0]        ram_addr_d;
  logic                     ram_cs_d, ram_we_d, ram_oe_d, err_d;
  logic [1:0]               ram_data_size_d;

  assign req  = m_cs & (m_we | m_oe);
  assign done = (state_q == ST_ISSUE) && ram_ready;
  assign tout = (state_q == ST_ISSUE) && !ram_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Lock narrows eligibility to lock_id; an out-of-range id matches nobody.
  always_comb begin
    elig = req;
    if (lock_en) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        elig[i] = req[i] && (lock_id == IDX_W'(i));
      end
    end
  end

  arb_pick #(.N(NUM_MASTERS)) u_pick (
    .req    (elig),
    .rr_ptr (rr_ptr_q),
    .rr_mode(RR),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    sel_we    = 1'b0;
    sel_oe    = 1'b0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_size  = m_size[i*2 +: 2];
        sel_we    = m_we[i];
        sel_oe    = m_oe[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE:   if (done || tout) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output and of the bookkeeping registers.
  always_comb begin
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    m_ready_d       = m_ready;
    m_rdata_d       = m_rdata;
    grant_d         = grant;
    ram_addr_d      = ram_addr;
    ram_d_in_d      = ram_d_in;
    ram_cs_d        = ram_cs;
    ram_we_d        = ram_we;
    ram_oe_d        = ram_oe;
    ram_data_size_d = ram_data_size;
    err_d           = err_clr ? 1'b0 : err;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d         = pick_idx;
          cnt_d           = '0;
          grant_d         = NUM_MASTERS'(1) << pick_idx;
          ram_addr_d      = sel_addr;
          ram_d_in_d      = sel_wdata;
          ram_data_size_d = sel_size;
          ram_we_d        = sel_we;
          ram_oe_d        = sel_oe;
          ram_cs_d        = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done || tout) begin
          m_ready_d = NUM_MASTERS'(1) << owner_q;
          m_rdata_d = (done && !ram_we) ? ram_d_out : '0;
          ram_cs_d  = 1'b0;
          ram_we_d  = 1'b0;
          ram_oe_d  = 1'b0;
          rr_ptr_d  = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
          if (tout) err_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        grant_d   = '0;
        m_ready_d = '0;
      end
      default: begin
        grant_d   = '0;
        m_ready_d = '0;
        ram_cs_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      m_ready       <= '0;
      m_rdata       <= '0;
      grant         <= '0;
      ram_addr      <= '0;
      ram_d_in      <= '0;
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      ram_oe        <= 1'b0;
      ram_data_size <= '0;
      err           <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      m_ready       <= m_ready_d;
      m_rdata       <= m_rdata_d;
      grant         <= grant_d;
      ram_addr      <= ram_addr_d;
      ram_d_in      <= ram_d_in_d;
      ram_cs        <= ram_cs_d;
      ram_we        <= ram_we_d;
      ram_oe        <= ram_oe_d;
      ram_data_size <= ram_data_size_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a fixed-priority 2-master instance (8-cycle watchdog) and a
// round-robin 3-master instance sharing clock and reset.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: NUM_MASTERS=2, fixed priority, TIMEOUT_CYCLES=8
  logic [1:0]  a_cs = '0, a_we = '0, a_oe = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_size = '0;
  logic [1:0]  a_m_ready, a_grant;
  logic [31:0] a_m_rdata, a_ram_addr, a_ram_d_in;
  logic        a_ram_cs, a_ram_we, a_ram_oe;
  logic [1:0]  a_ram_size;
  logic [31:0] a_ram_d_out = '0;
  logic        a_ram_ready, a_err;
  logic        a_err_clr = 1'b0, a_lock_en = 1'b0, a_auto = 1'b0, a_ready_man = 1'b0;
  logic [2:0]  a_lock_id = '0;
  assign a_ram_ready = a_auto ? a_ram_cs : a_ready_man;

  ram_port_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .rst(rst), .m_cs(a_cs), .m_we(a_we), .m_oe(a_oe), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_size(a_size), .m_ready(a_m_ready), .m_rdata(a_m_rdata),
    .grant(a_grant), .lock_en(a_lock_en), .lock_id(a_lock_id), .ram_addr(a_ram_addr),
    .ram_d_in(a_ram_d_in), .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_oe(a_ram_oe),
    .ram_data_size(a_ram_size), .ram_d_out(a_ram_d_out), .ram_ready(a_ram_ready),
    .err(a_err), .err_clr(a_err_clr)
  );

  // Instance B: NUM_MASTERS=3, round-robin, default watchdog
  logic [2:0]  b_cs = '0, b_we = '0, b_oe = '0;
  logic [95:0] b_addr = '0, b_wdata = '0;
  logic [5:0]  b_size = '0;
  logic [2:0]  b_m_ready, b_grant;
  logic [31:0] b_m_rdata, b_ram_addr, b_ram_d_in;
  logic        b_ram_cs, b_ram_we, b_ram_oe;
  logic [1:0]  b_ram_size;
  logic [31:0] b_ram_d_out = 32'hB0B0_B0B0;
  logic        b_ram_ready, b_err;
  logic        b_auto = 1'b0, b_ready_man = 1'b0;
  assign b_ram_ready = b_auto ? b_ram_cs : b_ready_man;

  ram_port_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT_CYCLES(64)) u_b (
    .clk(clk), .rst(rst), .m_cs(b_cs), .m_we(b_we), .m_oe(b_oe), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_size(b_size), .m_ready(b_m_ready), .m_rdata(b_m_rdata),
    .grant(b_grant), .lock_en(1'b0), .lock_id(3'd0), .ram_addr(b_ram_addr),
    .ram_d_in(b_ram_d_in), .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe),
    .ram_data_size(b_ram_size), .ram_d_out(b_ram_d_out), .ram_ready(b_ram_ready),
    .err(b_err), .err_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (a_ram_cs !== 1'b0) begin bad++; $display("FAIL rst_ram_cs got=%h exp=0", a_ram_cs); end
    total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%h exp=0", a_grant); end
    total++; if (a_m_ready !== 2'b00) begin bad++; $display("FAIL rst_m_ready got=%h exp=0", a_m_ready); end
    total++; if (a_m_rdata !== 32'h0) begin bad++; $display("FAIL rst_m_rdata got=%h exp=0", a_m_rdata); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%h exp=0", a_err); end
    total++; if (b_grant !== 3'b000) begin bad++; $display("FAIL rst_b_grant got=%h exp=0", b_grant); end
  endtask

  task automatic test_single_read();
    a_cs = 2'b10; a_oe = 2'b10; a_we = 2'b00;
    a_addr[32 +: 32] = 32'h100; a_ram_d_out = 32'hDEAD_BEEF;
    tick();
    total++; if (a_ram_cs !== 1'b1) begin bad++; $display("FAIL rd_cs got=%h exp=1", a_ram_cs); end
    total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL rd_grant got=%h exp=2", a_grant); end
    total++; if (a_ram_addr !== 32'h100) begin bad++; $display("FAIL rd_addr got=%h exp=100", a_ram_addr); end
    total++; if (a_ram_oe !== 1'b1 || a_ram_we !== 1'b0) begin bad++; $display("FAIL rd_oe_we got=%b%b exp=10", a_ram_oe, a_ram_we); end
    a_cs = 2'b00;
    tick();
    total++; if (a_m_ready !== 2'b00 || a_ram_cs !== 1'b1) begin bad++; $display("FAIL rd_wait got=%h/%h exp=0/1", a_m_ready, a_ram_cs); end
    a_ready_man = 1'b1;
    tick();
    a_ready_man = 1'b0;
    total++; if (a_m_ready !== 2'b10) begin bad++; $display("FAIL rd_ready got=%h exp=2", a_m_ready); end
    total++; if (a_m_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", a_m_rdata); end
    total++; if (a_ram_cs !== 1'b0) begin bad++; $display("FAIL rd_cs_drop got=%h exp=0", a_ram_cs); end
    tick();
    total++; if (a_m_ready !== 2'b00 || a_grant !== 2'b00) begin bad++; $display("FAIL rd_release got=%h/%h exp=0/0", a_m_ready, a_grant); end
  endtask

  task automatic test_fixed_priority();
    a_auto = 1'b1; a_cs = 2'b11; a_oe = 2'b11; a_we = 2'b00;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 6 && a_grant === 2'b00; i++) tick();
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL fixed_grant%0d got=%h exp=1", g, a_grant); end
      for (int i = 0; i < 6 && a_grant !== 2'b00; i++) tick();
    end
    a_cs = 2'b00; a_oe = 2'b00;
    tick(); tick();
    a_auto = 1'b0;
  endtask

  task automatic test_lock();
    int seen;
    seen = 0;
    a_lock_en = 1'b1; a_lock_id = 3'd0; a_auto = 1'b1;
    a_cs = 2'b11; a_we = 2'b01; a_oe = 2'b10;
    a_addr = {32'h200, 32'h40}; a_wdata = {32'h0, 32'h1234_5678}; a_size = {2'b00, 2'b11};
    for (int i = 0; i < 6 && a_grant === 2'b00; i++) tick();
    total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL lock_grant got=%h exp=1", a_grant); end
    total++; if (a_ram_we !== 1'b1 || a_ram_oe !== 1'b0) begin bad++; $display("FAIL lock_we_oe got=%b%b exp=10", a_ram_we, a_ram_oe); end
    total++; if (a_ram_size !== 2'b11) begin bad++; $display("FAIL lock_size got=%h exp=3", a_ram_size); end
    total++; if (a_ram_addr !== 32'h40 || a_ram_d_in !== 32'h1234_5678) begin bad++; $display("FAIL lock_addr_data got=%h/%h exp=40/12345678", a_ram_addr, a_ram_d_in); end
    a_cs = 2'b10;
    for (int i = 0; i < 6 && a_grant !== 2'b00; i++) tick();
    // master 1 still requesting: blocked by lock_id=0, then by out-of-range lock_id=2
    repeat (3) begin tick(); if (a_grant !== 2'b00) seen++; end
    a_lock_id = 3'd2;
    repeat (3) begin tick(); if (a_grant !== 2'b00) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL lock_block got=%0d grants exp=0", seen); end
    a_lock_en = 1'b0;
    for (int i = 0; i < 6 && a_grant === 2'b00; i++) tick();
    total++; if (a_grant !== 2'b10 || a_ram_addr !== 32'h200) begin bad++; $display("FAIL unlock_grant got=%h/%h exp=2/200", a_grant, a_ram_addr); end
    a_cs = 2'b00;
    for (int i = 0; i < 6 && a_grant !== 2'b00; i++) tick();
    a_auto = 1'b0; a_lock_id = 3'd0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    a_ram_d_out = 32'hCAFE_F00D;
    a_cs = 2'b01; a_oe = 2'b01; a_we = 2'b00;
    tick();
    total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL to_grant got=%h exp=1", a_grant); end
    a_cs = 2'b00;
    repeat (7) begin tick(); if (a_m_ready !== 2'b00 || a_ram_cs !== 1'b1) early++; end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early got=%0d exp=0", early); end
    tick();
    total++; if (a_m_ready !== 2'b01) begin bad++; $display("FAIL to_ready got=%h exp=1", a_m_ready); end
    total++; if (a_m_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", a_m_rdata); end
    total++; if (a_err !== 1'b1 || a_ram_cs !== 1'b0) begin bad++; $display("FAIL to_err got=%h/%h exp=1/0", a_err, a_ram_cs); end
    repeat (3) tick();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%h exp=1", a_err); end
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL to_clr got=%h exp=0", a_err); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    b_auto = 1'b1; b_cs = 3'b111; b_oe = 3'b111;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 6 && b_grant === 3'b000; i++) tick();
      total++; if (b_grant !== exp_g[g]) begin bad++; $display("FAIL rr_grant%0d got=%h exp=%h", g, b_grant, exp_g[g]); end
      for (int i = 0; i < 6 && b_grant !== 3'b000; i++) tick();
      total++; if (b_ram_cs !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%h exp=0", g, b_ram_cs); end
    end
    b_auto = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6 && b_grant === 3'b000; i++) tick();
    total++; if (b_grant !== 3'b010) begin bad++; $display("FAIL ar_pre_grant got=%h exp=2", b_grant); end
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (b_ram_cs !== 1'b0 || b_grant !== 3'b000 || b_m_ready !== 3'b000) begin bad++; $display("FAIL ar_async got=%h/%h/%h exp=0/0/0", b_ram_cs, b_grant, b_m_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    total++; if (b_grant !== 3'b001) begin bad++; $display("FAIL ar_rr_restart got=%h exp=1", b_grant); end
    b_ready_man = 1'b1;
    tick();
    b_ready_man = 1'b0;
    total++; if (b_m_ready !== 3'b001 || b_m_rdata !== 32'hB0B0_B0B0) begin bad++; $display("FAIL ar_complete got=%h/%h exp=1/b0b0b0b0", b_m_ready, b_m_rdata); end
    b_cs = 3'b000;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_lock();
    test_timeout();
    test_round_robin();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Parametrised N-master arbiter in front of the shared RAM: the successor to the single two-way loader/CPU mux.
- Serialises chip-select transactions from NUM_MASTERS masters onto one RAM port with cs/we/oe/data_size and a mem-done handshake.
- Supports fixed-priority or round-robin arbitration, a lock override (forces one master, e.g. the file loader during boot), and a per-transaction watchdog timeout.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..8); master 0 is highest fixed priority.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- RR_MODE, 0: 0 = fixed priority, 1 = round-robin.
- TIMEOUT_CYCLES, 64: cycles to wait for ram_ready before aborting (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_cs  in  NUM_MASTERS  per-master request/chip select.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_oe  in  NUM_MASTERS  per-master output enable.
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data.
- m_size  in  NUM_MASTERS*2  packed data_size codes (2'b11 = word).
- m_ready  out  NUM_MASTERS  one-cycle completion pulse to the owning master.
- m_rdata  out  DATA_W  read data, broadcast; valid while m_ready[i] is high.
- grant  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- lock_en  in  1  restrict arbitration to lock_id.
- lock_id  in  3  locked master index.
- ram_addr  out  ADDR_W  address to RAM.
- ram_d_in  out  DATA_W  write data to RAM.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_data_size  out  2  RAM access size.
- ram_d_out  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM mem-done.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async, any time, including mid-transaction): state IDLE; all outputs 0 (ram_* lines, m_ready, m_rdata, grant, err); rr_ptr = 0; timeout counter = 0. The aborted transaction is not reported to its master.
- Request: req[i] = m_cs[i] & (m_we[i] | m_oe[i]). When lock_en = 1, only req[lock_id] is eligible. lock_id ≥ NUM_MASTERS means no master is eligible.
- Winner selection:
  - Fixed mode: lowest eligible index wins.
  - RR mode: first eligible index at or above rr_ptr, wrapping modulo NUM_MASTERS.
- FSM states: IDLE, ISSUE, RELEASE. All outputs are registered.
  - IDLE: if any eligible request is present at edge n, latch the winner's addr/wdata/size/we/oe into ram_*. At n+1: ram_cs = 1, grant = onehot(winner); go to ISSUE. Otherwise stay, with ram_cs = 0.
  - ISSUE: ram_* held constant. Counter increments each cycle.
  - ISSUE completion: if ram_ready is sampled 1 at edge k, then at k+1: m_rdata = ram_d_out (0 for writes), m_ready[winner] = 1 for exactly one cycle, ram_cs/we/oe = 0; go to RELEASE.
  - ISSUE timeout: if the counter reaches TIMEOUT_CYCLES without ram_ready, apply the same exit with m_rdata = 0 and err set to 1.
  - RELEASE: one cycle, grant = 0, m_ready = 0; go to IDLE. This guarantees a cs-low gap so the RAM clears mem-done.
- Throughput: minimum 3 cycles per transaction (grant, ready sample, release). The next grant is earliest at k+3.
- RR pointer: after any completion or timeout, rr_ptr = winner + 1, wrapping to 0 after NUM_MASTERS-1. Fixed mode ignores rr_ptr.
- Changes during ISSUE:
  - The committed transaction completes regardless of the master dropping m_cs or changing its inputs.
  - lock_en/lock_id changes take effect at the next IDLE arbitration.
- Read-modify is not supported: a transaction with we = 1 and oe = 1 is issued to the RAM as-is.
- err: set by a timeout and sticky. err_clr clears it on the next edge; a timeout on the same edge wins (err stays 1).
- ram_ready while in IDLE or RELEASE is ignored.

Decomposition:
- Shared package/include: state encodings (ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RELEASE = 2'd2) and data-size codes (SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11).
- One sub-module, arb_pick: combinational priority/round-robin selector taking req, rr_ptr and mode; outputs winner index and a valid bit. The FSM, latching and timeout logic stay in ram_port_arbiter.

Test Plan:
- Single read: master 1 requests read at addr 0x100, RAM returns 0xDEADBEEF with ready after 2 cycles → ram_cs rises 1 cycle after the request; m_ready[1] pulses once with m_rdata = 0xDEADBEEF; grant returns to 0 one cycle later.
- Fixed priority, RR_MODE=0: masters 0 and 1 request continuously → 4 consecutive grants all go to master 0; master 1 is never granted.
- Round-robin, RR_MODE=1, NUM_MASTERS=3: all three request continuously → grant order 0, 1, 2, 0, with a cs-low gap of one cycle between transactions.
- Lock: lock_en=1, lock_id=0, master 1 requesting, master 0 writes 0x12345678 to 0x40 → only master 0 granted; the RAM sees we = 1, size = 2'b11; master 1 is granted after lock_en drops.
- Timeout, TIMEOUT_CYCLES=8: ram_ready held 0 → m_ready pulses after 8 ISSUE cycles with m_rdata = 0, err = 1 sticky; an err_clr pulse clears it.
- Async reset mid-ISSUE: assert rst between clock edges → ram_cs, grant and m_ready are 0 immediately; after release the FSM is in IDLE and rr_ptr = 0 (the next RR grant goes to master 0).
